// File: rtl/bcd_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bcd_share_arbiter_pkg
// Shared definitions for the BCD share arbiter:
//   BIN_W / BCD_W : operand and result widths of the shared converter
//   MAX_REQ       : widest requester vector the pick function handles
//   state_t       : arbiter FSM states
//   rr_pick()     : round-robin one-hot grant from a request vector
// ---------------------------------------------------------------------------
package bcd_share_arbiter_pkg;

    localparam int BIN_W   = 6;
    localparam int BCD_W   = 8;
    localparam int MAX_REQ = 8;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Searches upward from ptr, wrapping at n-1 -> 0, and returns a one-hot
    // vector for the first set request. Bits at or above n are never set.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req_vec,
        input logic [2:0]         ptr,
        input logic [3:0]         n
    );
        logic [MAX_REQ-1:0] g;
        logic               found;
        logic [3:0]         idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (4'(k) < n) && req_vec[idx[2:0]]) begin
                g[idx[2:0]] = 1'b1;
                found       = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/bcd_share_arbiter_conv.sv
// ---------------------------------------------------------------------------
// bcd_share_arbiter_conv
// Combinational 6-bit binary to two-digit BCD converter.
// Ports:
//   i_bin : binary operand, 0..63
//   o_bcd : {tens, ones}, each nibble 0..9
// ---------------------------------------------------------------------------
module bcd_share_arbiter_conv
    import bcd_share_arbiter_pkg::*;
(
    input  logic [BIN_W-1:0] i_bin,
    output logic [BCD_W-1:0] o_bcd
);

    logic [3:0] w_tens;
    logic [3:0] w_ones;

    // Operand never exceeds 63, so tens fits in one digit.
    always_comb begin
        w_tens = 4'(i_bin / 6'd10);
        w_ones = 4'(i_bin % 6'd10);
        o_bcd  = {w_tens, w_ones};
    end

endmodule

// File: rtl/bcd_share_arbiter.sv
// ---------------------------------------------------------------------------
// bcd_share_arbiter
// Round-robin sharing of one binary-to-BCD converter between NUM_REQ
// requesters, with a registered per-channel BCD result.
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req       : per-channel request, held until granted
//   bin_in    : per-channel 6-bit operand, channel i at [6i+5:6i]
//   gnt       : one-hot combinational grant; operand sampled at cycle end
//   bcd_out   : per-channel registered result, channel i at [8i+7:8i]
//   bcd_valid : one-cycle pulse when bcd_out[i] has just been updated
//   busy      : high while a conversion is in flight (CONV state)
// ---------------------------------------------------------------------------
module bcd_share_arbiter
    import bcd_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*BIN_W-1:0]   bin_in,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ*BCD_W-1:0]   bcd_out,
    output logic [NUM_REQ-1:0]         bcd_valid,
    output logic                       busy
);

    state_t             r_state;
    state_t             w_state_next;
    logic [2:0]         r_rr_ptr;
    logic [BIN_W-1:0]   r_op_reg;
    logic [2:0]         r_op_ch;

    logic [MAX_REQ-1:0] w_req_ext;
    logic [MAX_REQ-1:0] w_pick;
    logic [2:0]         w_win;
    logic               w_any;
    logic [BIN_W-1:0]   w_sel_bin;
    logic [BCD_W-1:0]   w_conv;
    logic               w_write;

    logic [BCD_W-1:0]   r_bcd   [NUM_REQ];
    logic               r_valid [NUM_REQ];

    // Arbiter: active in both states so back-to-back grants keep the
    // converter busy every cycle.
    always_comb begin
        w_req_ext                = '0;
        w_req_ext[NUM_REQ-1:0]   = req;
        w_pick                   = rr_pick(w_req_ext, r_rr_ptr, 4'(NUM_REQ));
        w_win                    = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (w_pick[k]) begin
                w_win = 3'(k);
            end
        end
        w_any     = |w_pick;
        w_sel_bin = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_win == 3'(k)) begin
                w_sel_bin = bin_in[k*BIN_W +: BIN_W];
            end
        end
    end

    // Grant is forced low during reset since it is combinational.
    assign gnt = rst_n ? w_pick[NUM_REQ-1:0] : '0;

    // FSM next-state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = w_any ? CONV : IDLE;
            CONV:    w_state_next = w_any ? CONV : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_op_reg <= '0;
            r_op_ch  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_any) begin
                r_rr_ptr <= (w_win == 3'(NUM_REQ-1)) ? 3'd0 : w_win + 3'd1;
                r_op_reg <= w_sel_bin;
                r_op_ch  <= w_win;
            end
        end
    end

    assign busy    = (r_state == CONV);
    assign w_write = (r_state == CONV);

    bcd_share_arbiter_conv u_conv (
        .i_bin (r_op_reg),
        .o_bcd (w_conv)
    );

    // Per-channel result registers; the valid pulse lasts exactly the cycle
    // after the write because every non-target channel clears each edge.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ch
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_bcd[gi]   <= '0;
                r_valid[gi] <= 1'b0;
            end else begin
                r_valid[gi] <= w_write && (r_op_ch == 3'(gi));
                if (w_write && (r_op_ch == 3'(gi))) begin
                    r_bcd[gi] <= w_conv;
                end
            end
        end
        assign bcd_out[gi*BCD_W +: BCD_W] = r_bcd[gi];
        assign bcd_valid[gi]              = r_valid[gi];
    end

endmodule

// File: tb/tb_bcd_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bcd_share_arbiter
// Directed stimulus with a scoreboard: each grant pushes the expected
// channel, value and arrival cycle; a monitor pops on every bcd_valid pulse.
// ---------------------------------------------------------------------------
module tb_bcd_share_arbiter;

    localparam int NUM_REQ = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [23:0] bin_in;
    logic [3:0]  gnt;
    logic [31:0] bcd_out;
    logic [3:0]  bcd_valid;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         ch;
        logic [7:0] val;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];

    bcd_share_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .bin_in    (bin_in),
        .gnt       (gnt),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic int oh2i(input logic [3:0] oh);
        int r;
        r = -1;
        for (int k = 0; k < 4; k++) if (oh[k]) r = k;
        return r;
    endfunction

    // Monitor: every valid pulse must match the oldest expected result.
    always @(negedge clk) begin : mon
        exp_t e;
        int   ch;
        if (rst_n === 1'b1 && bcd_valid !== 4'b0000) begin
            ch = oh2i(bcd_valid);
            check("valid_onehot", 32'($countones(bcd_valid)), 32'd1);
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got bcd_valid=%b cycle %0d required no pulse", bcd_valid, cyc);
            end else begin
                e = sb_q.pop_front();
                $display("[TB] result ch%0d bcd=%02h cycle %0d", ch, bcd_out[ch*8 +: 8], cyc);
                check("valid_ch", 32'(ch), 32'(e.ch));
                check("valid_cycle", 32'(cyc), 32'(e.cyc));
                check("bcd_value", {24'd0, bcd_out[e.ch*8 +: 8]}, {24'd0, e.val});
                check("nibbles_le_9", 32'((bcd_out[e.ch*8+4 +: 4] <= 4'd9) && (bcd_out[e.ch*8 +: 4] <= 4'd9)), 32'd1);
            end
        end
    end

    task automatic set_bin(input int ch, input logic [5:0] v);
        bin_in[ch*6 +: 6] = v;
    endtask

    // One cycle of stimulus; entered and left at posedge+1.
    task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [7:0] ev,
                        input logic eb, input bit push, input string nm);
        req = r;
        @(negedge clk);
        check({nm, "_gnt"}, {28'd0, gnt}, {28'd0, eg});
        check({nm, "_busy"}, {31'd0, busy}, {31'd0, eb});
        if (push && eg != 4'b0000) sb_q.push_back('{oh2i(eg), ev, cyc + 2});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        req   = 4'b1111;
        rst_n = 1'b0;
        #1;
        check({nm, "_gnt_in_reset"}, {28'd0, gnt}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        req   = 4'b0000;
        rst_n = 1'b1;
        @(negedge clk);
        check({nm, "_bcd_out"}, bcd_out, 32'd0);
        check({nm, "_valid"}, {28'd0, bcd_valid}, 32'd0);
        check({nm, "_busy"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 of the CONV cycle following an unpushed grant.
    task automatic mid_conv_reset(input int ch, input string nm);
        rst_n = 1'b0;
        req   = 4'b1111;
        #1;
        check({nm, "_gnt_in_reset"}, {28'd0, gnt}, 32'd0);
        check({nm, "_ch_zero"}, {24'd0, bcd_out[ch*8 +: 8]}, 32'd0);
        @(negedge clk);
        check({nm, "_valid_in_reset"}, {28'd0, bcd_valid}, 32'd0);
        @(posedge clk);
        #1;
        req   = 4'b0000;
        rst_n = 1'b1;
        @(negedge clk);
        check({nm, "_ch_after"}, {24'd0, bcd_out[ch*8 +: 8]}, 32'd0);
        check({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] ops  [6];
        logic [7:0] exps [6];
        ops  = '{6'd0, 6'd9, 6'd10, 6'd59, 6'd60, 6'd63};
        exps = '{8'h00, 8'h09, 8'h10, 8'h59, 8'h60, 8'h63};
        rst_n  = 1'b0;
        req    = 4'b0000;
        bin_in = '0;

        // Single request on ch0.
        do_reset("t1_rst");
        set_bin(0, 6'd45);
        step(4'b0001, 4'b0001, 8'h45, 1'b0, 1'b1, "t1_c0");
        step(4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1, "t1_c1");
        step(4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, "t1_c2");
        step(4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, "t1_c3");

        // All four channels at once.
        do_reset("t2_rst");
        set_bin(0, 6'd7);
        set_bin(1, 6'd19);
        set_bin(2, 6'd38);
        set_bin(3, 6'd63);
        step(4'b1111, 4'b0001, 8'h07, 1'b0, 1'b1, "t2_c0");
        step(4'b1110, 4'b0010, 8'h19, 1'b1, 1'b1, "t2_c1");
        step(4'b1100, 4'b0100, 8'h38, 1'b1, 1'b1, "t2_c2");
        step(4'b1000, 4'b1000, 8'h63, 1'b1, 1'b1, "t2_c3");
        step(4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1, "t2_c4");
        step(4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, "t2_c5");
        step(4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, "t2_c6");

        // ch0 and ch2 held: grants must alternate (pointer is 0 here).
        set_bin(0, 6'd12);
        set_bin(2, 6'd33);
        step(4'b0101, 4'b0001, 8'h12, 1'b0, 1'b1, "t3_c0");
        step(4'b0101, 4'b0100, 8'h33, 1'b1, 1'b1, "t3_c1");
        step(4'b0101, 4'b0001, 8'h12, 1'b1, 1'b1, "t3_c2");
        step(4'b0101, 4'b0100, 8'h33, 1'b1, 1'b1, "t3_c3");
        step(4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1, "t3_c4");
        step(4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, "t3_c5");
        step(4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, "t3_c6");

        // Boundary sweep on ch1, back-to-back grants to the same channel.
        for (int i = 0; i < 6; i++) begin
            set_bin(1, ops[i]);
            step(4'b0010, 4'b0010, exps[i], (i == 0) ? 1'b0 : 1'b1, 1'b1, "t4_sweep");
        end
        step(4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1, "t4_tail0");
        step(4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, "t4_tail1");
        step(4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, "t4_tail2");

        // Reset in the middle of a ch3 conversion: result must be discarded.
        do_reset("t5_rst");
        set_bin(3, 6'd50);
        step(4'b1000, 4'b1000, 8'h50, 1'b0, 1'b0, "t5_grant");
        mid_conv_reset(3, "t5");
        step(4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, "t5_idle0");
        step(4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, "t5_idle1");

        // After reset, ch3 alone is granted and converts normally.
        step(4'b1000, 4'b1000, 8'h50, 1'b0, 1'b1, "t6_c0");
        step(4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1, "t6_c1");
        step(4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, "t6_c2");
        step(4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, "t6_c3");

        // Pointer restart: grant ch2 (pointer -> 3), reset, then req ch0+ch3
        // must go to ch0.
        set_bin(2, 6'd21);
        step(4'b0100, 4'b0100, 8'h21, 1'b0, 1'b0, "t7_grant");
        mid_conv_reset(2, "t7");
        step(4'b1001, 4'b0001, 8'h12, 1'b0, 1'b1, "t7_ptr");
        step(4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1, "t7_c1");
        step(4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, "t7_c2");
        step(4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, "t7_c3");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
